// File: rtl/wb_commit_arbiter_pkg.sv
// Shared definitions for the write-back commit arbiter: datapath widths,
// the x0 register address and the buffered load-result entry.
package wb_commit_arbiter_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  // x0 is hardwired to zero, so a result aimed at it never produces a write strobe.
  function automatic logic writes_reg(input logic [REG_ADDR_W-1:0] rd);
    return rd != REG_ZERO;
  endfunction

endpackage

// File: rtl/wb_commit_arbiter_if.sv
// Bundle of the ALU channel, load channel and register-file write port.
// The slave modport is the arbiter's view; master is the surrounding pipeline.
interface wb_commit_arbiter_if #(
  parameter int DEPTH = 4
) ();
  import wb_commit_arbiter_pkg::*;

  logic                   alu_valid;
  logic                   alu_ready;
  logic [REG_ADDR_W-1:0]  alu_rd;
  logic [XLEN-1:0]        alu_data;

  logic                   mem_valid;
  logic                   mem_ready;
  logic [REG_ADDR_W-1:0]  mem_rd;
  logic [XLEN-1:0]        mem_data;

  logic                   rd_we;
  logic [REG_ADDR_W-1:0]  writeReg;
  logic [XLEN-1:0]        writeData;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   idle;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready,
    output rd_we, writeReg, writeData, fifo_count, idle
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready,
    input  rd_we, writeReg, writeData, fifo_count, idle
  );

endinterface

// File: rtl/wb_commit_arbiter_fifo.sv
// Synchronous load-result FIFO with a combinational head view. The count is one
// bit wider than the pointers so full and empty stay distinguishable.
module wb_fifo
  import wb_commit_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  wb_entry_t              i_push_data,
  input  logic                   i_pop,
  output wb_entry_t              o_head,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  // Guard against illegal requests so the pointers can never run past each other.
  assign w_do_pop  = i_pop  && (r_count != '0);
  assign w_do_push = i_push && (r_count != FULL_CNT);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/wb_commit_arbiter.sv
// Merges ALU results and buffered load results into one registered register-file
// write port. ALU wins by default; a starvation counter forces the load head out.
module wb_commit_arbiter
  import wb_commit_arbiter_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 3
) (
  input logic                clk,
  input logic                rst_n,
  wb_commit_arbiter_if.slave bus
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [CNT_W-1:0]      w_count;
  wb_entry_t             w_head;
  wb_entry_t             w_push_entry;
  wb_entry_t             w_sel_entry;
  logic                  w_count_nz;
  logic                  w_full;
  logic                  w_force;
  logic                  w_sel_alu;
  logic                  w_pop;
  logic                  w_selected;
  logic                  w_push;

  logic [WAIT_W-1:0]     r_wait;
  logic                  r_rd_we;
  logic [REG_ADDR_W-1:0] r_write_reg;
  logic [XLEN-1:0]       r_write_data;

  assign w_push_entry.rd   = bus.mem_rd;
  assign w_push_entry.data = bus.mem_data;
  assign w_push            = bus.mem_valid && !w_full;

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_push_data(w_push_entry),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_count    (w_count)
  );

  // Selection looks only at registered state, so both readies are independent of same-cycle valids.
  always_comb begin
    w_count_nz  = (w_count != '0);
    w_full      = (w_count == FULL_CNT);
    w_force     = w_full || (w_count_nz && (r_wait == WAIT_MAX));
    w_sel_alu   = 1'b0;
    w_pop       = 1'b0;
    w_sel_entry = '0;
    if (w_force) begin
      w_pop       = 1'b1;
      w_sel_entry = w_head;
    end else if (bus.alu_valid) begin
      w_sel_alu        = 1'b1;
      w_sel_entry.rd   = bus.alu_rd;
      w_sel_entry.data = bus.alu_data;
    end else if (w_count_nz) begin
      w_pop       = 1'b1;
      w_sel_entry = w_head;
    end
    w_selected = w_sel_alu || w_pop;
  end

  // Counts cycles the head has been bypassed; a pop or an empty FIFO restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait <= '0;
    end else if (w_pop || !w_count_nz) begin
      r_wait <= '0;
    end else if (r_wait != WAIT_MAX) begin
      r_wait <= r_wait + WAIT_W'(1);
    end
  end

  // Address/data hold between commits; x0 results update them but never strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_we      <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
    end else begin
      r_rd_we <= w_selected && writes_reg(w_sel_entry.rd);
      if (w_selected) begin
        r_write_reg  <= w_sel_entry.rd;
        r_write_data <= w_sel_entry.data;
      end
    end
  end

  assign bus.alu_ready  = !w_force;
  assign bus.mem_ready  = !w_full;
  assign bus.rd_we      = r_rd_we;
  assign bus.writeReg   = r_write_reg;
  assign bus.writeData  = r_write_data;
  assign bus.fifo_count = w_count;
  assign bus.idle       = !w_count_nz && !r_rd_we;

endmodule

// File: tb/tb_wb_commit_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a queue-based reference model of the commit rules.
module tb_wb_commit_arbiter;

  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 3;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic clk;
  logic rst_n;

  wb_commit_arbiter_if #(.DEPTH(DEPTH)) bus ();

  wb_commit_arbiter #(
    .DEPTH   (DEPTH),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  ent_t        m_q[$];
  int          m_wait;
  bit          m_we;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  int          n_commits;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_wait = 0;
    m_we   = 1'b0;
    m_reg  = '0;
    m_data = '0;
  endtask

  function automatic bit model_force();
    return (m_q.size() == DEPTH) || (m_q.size() != 0 && m_wait == MAX_WAIT);
  endfunction

  task automatic check_outputs();
    chk("fifo_count", 64'(bus.fifo_count), 64'(m_q.size()));
    chk("mem_ready", 64'(bus.mem_ready), 64'(m_q.size() < DEPTH));
    chk("alu_ready", 64'(bus.alu_ready), 64'(!model_force()));
    chk("rd_we", 64'(bus.rd_we), 64'(m_we));
    chk("writeReg", 64'(bus.writeReg), 64'(m_reg));
    chk("writeData", 64'(bus.writeData), 64'(m_data));
    chk("idle", 64'(bus.idle), 64'(m_q.size() == 0 && !m_we));
    if (bus.rd_we) chk("x0_write", 64'(bus.writeReg == 5'd0), 64'(0));
  endtask

  // One clock: check current outputs, offer inputs, advance the model across the edge.
  task automatic cycle(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                       input bit mv, input logic [4:0] mrd, input logic [31:0] md);
    int   n;
    bit   popped;
    bit   sel;
    ent_t e;
    check_outputs();
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_data  = ad;
    bus.mem_valid = mv;
    bus.mem_rd    = mrd;
    bus.mem_data  = md;
    n      = m_q.size();
    popped = 1'b0;
    sel    = 1'b0;
    e.rd   = '0;
    e.data = '0;
    if (model_force() || (!av && n != 0)) begin
      e      = m_q.pop_front();
      popped = 1'b1;
      sel    = 1'b1;
    end else if (av) begin
      e.rd   = ard;
      e.data = ad;
      sel    = 1'b1;
    end
    m_we = sel && (e.rd != 5'd0);
    if (sel) begin
      m_reg  = e.rd;
      m_data = e.data;
    end
    if (m_we) n_commits++;
    if (popped || n == 0) m_wait = 0;
    else if (m_wait < MAX_WAIT) m_wait = m_wait + 1;
    if (mv && n < DEPTH) begin
      ent_t p;
      p.rd   = mrd;
      p.data = md;
      m_q.push_back(p);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.alu_valid = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_data  = '0;
    bus.mem_valid = 1'b0;
    bus.mem_rd    = '0;
    bus.mem_data  = '0;
    n_commits     = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd_we", 64'(bus.rd_we), 64'(0));
    chk("reset_count", 64'(bus.fifo_count), 64'(0));
    chk("reset_idle", 64'(bus.idle), 64'(1));
    chk("reset_writeReg", 64'(bus.writeReg), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ALU only, then an x0 result that is accepted but never strobes.
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    chk("alu_we", 64'(bus.rd_we), 64'(1));
    chk("alu_reg", 64'(bus.writeReg), 64'(5));
    chk("alu_data", 64'(bus.writeData), 64'hDEADBEEF);
    chk("alu_x0_ready", 64'(bus.alu_ready), 64'(1));
    cycle(1'b1, 5'd0, 32'h00001234, 1'b0, 5'd0, 32'd0);
    chk("alu_x0_we", 64'(bus.rd_we), 64'(0));
    idle_cycles(1);

    // Single load into an empty FIFO: no bypass, commits one cycle after it lands.
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hCAFE0001);
    chk("load_count", 64'(bus.fifo_count), 64'(1));
    chk("load_we_early", 64'(bus.rd_we), 64'(0));
    idle_cycles(1);
    chk("load_we", 64'(bus.rd_we), 64'(1));
    chk("load_reg", 64'(bus.writeReg), 64'(7));
    chk("load_data", 64'(bus.writeData), 64'hCAFE0001);
    idle_cycles(1);
    chk("load_idle", 64'(bus.idle), 64'(1));

    // Starvation: ALU held high wins MAX_WAIT cycles, then the load is forced.
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99990009);
    for (int i = 0; i <= MAX_WAIT; i++) begin
      chk("starve_ready", 64'(bus.alu_ready), 64'(i < MAX_WAIT));
      cycle(1'b1, 5'(10 + i), 32'hA0000000 + 32'(i), 1'b0, 5'd0, 32'd0);
    end
    chk("starve_reg", 64'(bus.writeReg), 64'(9));
    chk("starve_we", 64'(bus.rd_we), 64'(1));
    idle_cycles(2);

    // Full FIFO while the ALU keeps priority.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 5'(20 + i), 32'hB0000000 + 32'(i), 1'b1, 5'(1 + i), 32'hC0000000 + 32'(i));
    end
    chk("full_count", 64'(bus.fifo_count), 64'(DEPTH));
    chk("full_mem_ready", 64'(bus.mem_ready), 64'(0));
    chk("full_alu_ready", 64'(bus.alu_ready), 64'(0));
    cycle(1'b1, 5'd30, 32'hB00000FF, 1'b1, 5'd31, 32'hC00000FF);
    chk("full_forced_reg", 64'(bus.writeReg), 64'(1));
    chk("full_after_ready", 64'(bus.mem_ready), 64'(1));
    chk("full_after_count", 64'(bus.fifo_count), 64'(DEPTH - 1));
    idle_cycles(6);

    // Random mixed traffic, including x0 destinations and bursts on both channels.
    for (int i = 0; i < 600; i++) begin
      bit         av;
      bit         mv;
      logic [4:0] ard;
      logic [4:0] mrd;
      av  = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 35));
      mv  = ($urandom_range(0, 99) < 45);
      ard = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      mrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      cycle(av, ard, $urandom, mv, mrd, $urandom);
    end
    idle_cycles(8);

    // Asynchronous reset mid-stream with two loads buffered.
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33333333);
    cycle(1'b1, 5'd4, 32'h44444444, 1'b1, 5'd6, 32'h66666666);
    chk("pre_reset_count", 64'(bus.fifo_count), 64'(2));
    #2;
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rd_we", 64'(bus.rd_we), 64'(0));
    chk("async_count", 64'(bus.fifo_count), 64'(0));
    chk("async_idle", 64'(bus.idle), 64'(1));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle_cycles(2);
    cycle(1'b1, 5'd12, 32'h0BADF00D, 1'b0, 5'd0, 32'd0);
    chk("post_reset_reg", 64'(bus.writeReg), 64'(12));
    idle_cycles(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
